// File: rtl/cpu_id.sv
// Two-stage accumulator CPU: fetch from a combinational instruction ROM into decode_reg,
// execute the held instruction against ACCU and a 256x16 data memory.

module cpu_id_imem (
    input  logic [7:0]  addr,
    output logic [15:0] data
);
    // Contents come from a hierarchical preload; there is no write port.
    logic [15:0] mem [0:255];

    assign data = mem[addr];
endmodule

module cpu_id (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] io_out,
    output logic        io_exit,
    output logic [7:0]  io_pc
);
    typedef struct packed {
        logic [15:0] instr;
        logic [7:0]  pc;
    } decode_t;

    localparam logic [3:0] OP_NOP  = 4'h0, OP_LDI = 4'h1, OP_ADDI = 4'h2, OP_SUBI = 4'h3,
                           OP_LD   = 4'h4, OP_ST  = 4'h5, OP_ADD  = 4'h6, OP_SUB  = 4'h7,
                           OP_AND  = 4'h8, OP_OR  = 4'h9, OP_XOR  = 4'hA, OP_SHFT = 4'hB,
                           OP_JMP  = 4'hC, OP_JZ  = 4'hD, OP_JNZ  = 4'hE, OP_EXIT = 4'hF;

    logic [7:0]  pc;
    logic [15:0] accu, accu_nxt;
    decode_t     decode_reg;
    logic        exit_r;
    logic [15:0] imem_data;
    logic [15:0] dmem [0:255];

    logic [3:0]  opcode;
    logic [7:0]  imm;
    logic [15:0] imm_z, dval;
    logic        taken, st_en, halt;

    cpu_id_imem imem_inst (
        .addr (pc),
        .data (imem_data)
    );

    assign opcode = decode_reg.instr[15:12];
    assign imm    = decode_reg.instr[7:0];
    assign imm_z  = {8'h00, imm};
    assign dval   = dmem[imm];

    // Captured pc and the reserved field are carried for debug visibility only.
    logic unused_fields;
    assign unused_fields = ^{decode_reg.pc, decode_reg.instr[11:8]};

    always_comb begin
        accu_nxt = accu;
        taken    = 1'b0;
        st_en    = 1'b0;
        halt     = 1'b0;
        unique case (opcode)
            OP_LDI:  accu_nxt = imm_z;
            OP_ADDI: accu_nxt = accu + imm_z;
            OP_SUBI: accu_nxt = accu - imm_z;
            OP_LD:   accu_nxt = dval;
            OP_ST:   st_en    = 1'b1;
            OP_ADD:  accu_nxt = accu + dval;
            OP_SUB:  accu_nxt = accu - dval;
            OP_AND:  accu_nxt = accu & dval;
            OP_OR:   accu_nxt = accu | dval;
            OP_XOR:  accu_nxt = accu ^ dval;
            OP_SHFT: accu_nxt = imm[4] ? (accu >> imm[3:0]) : (accu << imm[3:0]);
            OP_JMP:  taken    = 1'b1;
            OP_JZ:   taken    = (accu == 16'h0000);
            OP_JNZ:  taken    = (accu != 16'h0000);
            OP_EXIT: halt     = 1'b1;
            default: ;
        endcase
    end

    // EXIT freezes fetch on the same edge it raises io_exit, so io_pc stops at the EXIT's successor.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc         <= 8'h00;
            accu       <= 16'h0000;
            decode_reg <= '0;
            exit_r     <= 1'b0;
        end else if (!exit_r) begin
            accu <= accu_nxt;
            if (halt) begin
                exit_r <= 1'b1;
            end else if (taken) begin
                pc         <= imm;
                decode_reg <= '{instr: 16'h0000, pc: pc};
            end else begin
                decode_reg <= '{instr: imem_data, pc: pc};
                pc         <= pc + 8'd1;
            end
        end
    end

    // Data memory is deliberately not reset; read-after-store works because reads are combinational.
    always_ff @(posedge clk) begin
        if (st_en && !exit_r)
            dmem[imm] <= accu;
    end

    assign io_out  = accu;
    assign io_exit = exit_r;
    assign io_pc   = pc;
endmodule

// File: tb/tb_cpu_id.sv
// Bench for cpu_id: directed programs with hand-computed expectations plus random programs
// checked every cycle against an instruction-level reference model.

module tb_cpu_id;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] io_out;
    logic        io_exit;
    logic [7:0]  io_pc;

    cpu_id dut (
        .clk     (clk),
        .rst     (rst),
        .io_out  (io_out),
        .io_exit (io_exit),
        .io_pc   (io_pc)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    bit cmp_en  = 1'b0;

    logic [15:0] prog   [256];
    logic [15:0] m_dmem [256];
    logic [7:0]  m_pc;
    logic [15:0] m_acc, m_ins, m_nacc, m_d;
    logic        m_exit, m_taken;
    logic [3:0]  m_op;
    logic [7:0]  m_imm;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one instruction retires per cycle; the instruction held this cycle was fetched last cycle.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pc = 8'h00; m_acc = 16'h0; m_ins = 16'h0; m_exit = 1'b0;
        end else if (!m_exit) begin
            m_op    = m_ins[15:12];
            m_imm   = m_ins[7:0];
            m_d     = m_dmem[m_imm];
            m_nacc  = m_acc;
            m_taken = (m_op == 4'hC) || (m_op == 4'hD && m_acc == 0) || (m_op == 4'hE && m_acc != 0);
            case (m_op)
                4'h1: m_nacc = 16'(m_imm);
                4'h2: m_nacc = 16'(int'(m_acc) + int'(m_imm));
                4'h3: m_nacc = 16'(int'(m_acc) - int'(m_imm));
                4'h4: m_nacc = m_d;
                4'h5: m_dmem[m_imm] = m_acc;
                4'h6: m_nacc = 16'(int'(m_acc) + int'(m_d));
                4'h7: m_nacc = 16'(int'(m_acc) - int'(m_d));
                4'h8: m_nacc = m_acc & m_d;
                4'h9: m_nacc = m_acc | m_d;
                4'hA: m_nacc = m_acc ^ m_d;
                4'hB: m_nacc = m_imm[4] ? 16'(int'(m_acc) / (1 << m_imm[3:0]))
                                        : 16'(int'(m_acc) * (1 << m_imm[3:0]));
                default: ;
            endcase
            if (m_op == 4'hF) m_exit = 1'b1;
            else if (m_taken) begin m_pc = m_imm; m_ins = 16'h0; end
            else begin m_ins = prog[m_pc]; m_pc = 8'(m_pc + 1); end
            m_acc = m_nacc;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_pc",   32'(io_pc),   32'(m_pc));
            chk("model_out",  32'(io_out),  32'(m_acc));
            chk("model_exit", 32'(io_exit), 32'(m_exit));
        end
    end

    task automatic load_prog();
        for (int i = 0; i < 256; i++) dut.imem_inst.mem[i] = prog[i];
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog[i] = 16'h0000;
    endtask

    // Reset changes land 2 time units after a falling edge to stay clear of both edges.
    task automatic do_reset();
        @(negedge clk); #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_exit(input string name, input int budget, output int n);
        n = 0;
        while (!io_exit && n < budget) begin
            edges(1);
            n++;
        end
        chk(name, 32'(io_exit), 32'd1);
    endtask

    task automatic gen_random_prog();
        logic [3:0] op;
        logic [7:0] imm;
        for (int j = 0; j < 8; j++) begin
            prog[2*j]   = {8'h10, 8'($urandom)};
            prog[2*j+1] = {8'h50, 8'(8'h40 + j)};
        end
        for (int i = 16; i < 256; i++) begin
            op  = 4'($urandom_range(0, 14));
            if ($urandom_range(0, 63) == 0) op = 4'hF;
            imm = 8'($urandom);
            if (op >= 4'h4 && op <= 4'hA) imm = 8'(8'h40 + $urandom_range(0, 7));
            prog[i] = {op, 4'($urandom), imm};
        end
    endtask

    int n;
    bit saw_aa;

    initial begin
        clear_prog();
        load_prog();

        // Reset held: outputs pinned at their reset values, then PC counts up through NOPs.
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            edges(1);
            chk("rst_pc", 32'(io_pc), 32'h00);
            chk("rst_out", 32'(io_out), 32'h0000);
            chk("rst_exit", 32'(io_exit), 32'd0);
        end
        @(negedge clk); #2 rst = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            edges(1);
            chk("release_pc", 32'(io_pc), 32'(k));
        end
        cmp_en = 1'b1;

        // Immediate arithmetic then EXIT.
        clear_prog();
        prog[0] = 16'h1005; prog[1] = 16'h2003; prog[2] = 16'h3008; prog[3] = 16'hF000;
        load_prog();
        do_reset();
        edges(2); chk("imm_ldi", 32'(io_out), 32'h0005);
        edges(1); chk("imm_addi", 32'(io_out), 32'h0008);
        edges(1); chk("imm_subi", 32'(io_out), 32'h0000);
        chk("imm_noexit_yet", 32'(io_exit), 32'd0);
        edges(1); chk("imm_exit", 32'(io_exit), 32'd1);
        edges(3);
        chk("imm_exit_held", 32'(io_exit), 32'd1);
        chk("imm_out_held", 32'(io_out), 32'h0000);
        chk("imm_pc_frozen", 32'(io_pc), 32'h04);

        // Store/load and 16-bit wrap-around.
        clear_prog();
        prog[0] = 16'h10FF; prog[1] = 16'h5010; prog[2] = 16'h1000; prog[3] = 16'h6010;
        prog[4] = 16'h6010; prog[5] = 16'h1000; prog[6] = 16'h3001; prog[7] = 16'hF000;
        prog[8] = 16'h10FF; prog[9] = 16'h5020; prog[10] = 16'h4020;
        load_prog();
        do_reset();
        edges(6); chk("mem_add2", 32'(io_out), 32'h01FE);
        edges(2); chk("mem_subi_wrap", 32'(io_out), 32'hFFFF);
        edges(1); chk("mem_exit", 32'(io_exit), 32'd1);

        // Taken jump flushes the wrong-path LDI.
        clear_prog();
        prog[2] = 16'hC008; prog[3] = 16'h10AA; prog[8] = 16'hF000;
        load_prog();
        do_reset();
        saw_aa = 1'b0;
        edges(2); chk("jmp_pc0", 32'(io_pc), 32'h02);
        edges(1); chk("jmp_pc1", 32'(io_pc), 32'h03);
        edges(1); chk("jmp_pc2", 32'(io_pc), 32'h08);
        edges(1); chk("jmp_pc3", 32'(io_pc), 32'h09);
        for (int i = 0; i < 4; i++) begin
            if (io_out == 16'h00AA) saw_aa = 1'b1;
            edges(1);
        end
        chk("jmp_no_aa", 32'(saw_aa), 32'd0);
        chk("jmp_exit", 32'(io_exit), 32'd1);
        chk("jmp_pc_final", 32'(io_pc), 32'h09);

        // Countdown loop: JNZ taken twice, exit on the 11th edge after release.
        clear_prog();
        prog[0] = 16'h1003; prog[1] = 16'h3001; prog[2] = 16'hE001; prog[3] = 16'hF000;
        load_prog();
        do_reset();
        edges(2); chk("loop_acc3", 32'(io_out), 32'd3);
        edges(1); chk("loop_acc2", 32'(io_out), 32'd2);
        edges(3); chk("loop_acc1", 32'(io_out), 32'd1);
        edges(3); chk("loop_acc0", 32'(io_out), 32'd0);
        chk("loop_not_done", 32'(io_exit), 32'd0);
        wait_exit("loop_exit", 20, n);
        chk("loop_exit_cycles", 32'(n), 32'd2);
        chk("loop_out", 32'(io_out), 32'h0000);

        // Asynchronous reset mid-loop and after exit: clears between edges.
        do_reset();
        edges(5);
        #2 rst = 1'b0;
        #1;
        chk("async_pc", 32'(io_pc), 32'h00);
        chk("async_out", 32'(io_out), 32'h0000);
        chk("async_exit", 32'(io_exit), 32'd0);
        @(negedge clk); #2 rst = 1'b1;
        wait_exit("async_rerun_exit", 40, n);
        @(negedge clk); #2 rst = 1'b0;
        #1 chk("async_exit_clear", 32'(io_exit), 32'd0);
        @(negedge clk); #2 rst = 1'b1;

        // Random programs, with one extra asynchronous reset part-way through each.
        for (int p = 0; p < 6; p++) begin
            clear_prog();
            gen_random_prog();
            load_prog();
            do_reset();
            repeat ($urandom_range(50, 250)) @(posedge clk);
            @(negedge clk); #2 rst = 1'b0;
            @(negedge clk); #2 rst = 1'b1;
            repeat (300) @(posedge clk);
        end

        @(negedge clk);
        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
